// File: rtl/dff_share_pkg_160_163.sv
// dff_share_pkg_160_163: state encoding, hold-counter width and clog2 helper shared by the arbiter files
package dff_share_pkg_160_163;
    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
    localparam int CNT_W = 4;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction
endpackage

// File: rtl/dff_share_arb_160_163_if.sv
// dff_share_arb_160_163_if: requester-side bus of the shared register (optional DFF_SHARE_WRCNT_EN adds wrcnt/last_id)
interface dff_share_arb_160_163_if import dff_share_pkg_160_163::*; #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] d_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           valid;
    logic           busy;
`ifdef DFF_SHARE_WRCNT_EN
    localparam int IW = clog2(N);
    logic [15:0]    wrcnt;
    logic [IW-1:0]  last_id;
    modport master (output req, d_in, input gnt, q, valid, busy, wrcnt, last_id);
    modport slave  (input req, d_in, output gnt, q, valid, busy, wrcnt, last_id);
`else
    modport master (output req, d_in, input gnt, q, valid, busy);
    modport slave  (input req, d_in, output gnt, q, valid, busy);
`endif
endinterface

// File: rtl/rr_pick_160_163.sv
// rr_pick_160_163: combinational round-robin winner search starting at ptr_i and wrapping at N
module rr_pick_160_163 import dff_share_pkg_160_163::*; #(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] win_o,
    output logic          any_o
);
    assign any_o = |req_i;
    // scan offsets from farthest to nearest so the nearest set bit after ptr_i wins
    always_comb begin
        win_o = '0;
        for (int k = N - 1; k >= 0; k--)
            win_o = req_i[(int'(ptr_i) + k) % N] ? IW'((int'(ptr_i) + k) % N) : win_o;
    end
endmodule

// File: rtl/dff_share_arb_160_163.sv
// dff_share_arb_160_163: round-robin sharing of one W-bit register among N requesters; DFF_SHARE_WRCNT_EN adds write count and last winner
module dff_share_arb_160_163 import dff_share_pkg_160_163::*; #(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    dff_share_arb_160_163_if.slave  bus
);
    localparam int IW = clog2(N);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;
    logic [IW-1:0]    win;
    logic             any;
    logic             grant;
    logic [N-1:0]     gnt_q;
    logic [W-1:0]     q_q;
    logic             valid_q;
    logic             busy_q;
    rr_pick_160_163 #(.N(N), .IW(IW)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (any)
    );
    assign grant = (state_q == ST_IDLE) && any;
    assign ptr_d = (int'(win) == N - 1) ? '0 : win + 1'b1;
    // arbitration FSM: load winner's slice on a grant edge, then sit out the hold window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            gnt_q <= grant ? (N'(1) << win) : '0;
            if (grant) begin
                q_q     <= bus.d_in[win*W +: W];
                valid_q <= 1'b1;
                ptr_q   <= ptr_d;
                if (HOLD_CYCLES != 0) begin
                    state_q <= ST_HOLD;
                    cnt_q   <= CNT_W'(HOLD_CYCLES);
                    busy_q  <= 1'b1;
                end
            end
            if (state_q == ST_HOLD) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end
        end
    end
    assign bus.gnt   = gnt_q;
    assign bus.q     = q_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
`ifdef DFF_SHARE_WRCNT_EN
    logic [15:0]   wrcnt_q;
    logic [IW-1:0] last_q;
    // count grant edges (wrapping) and remember the most recent winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrcnt_q <= '0;
            last_q  <= '0;
        end else if (grant) begin
            wrcnt_q <= wrcnt_q + 16'd1;
            last_q  <= win;
        end
    end
    assign bus.wrcnt   = wrcnt_q;
    assign bus.last_id = last_q;
`endif
endmodule

// File: tb/tb_dff_share_arb_160_163.sv
// tb_dff_share_arb_160_163: directed plus random stimulus against a behavioural model, HOLD=2 and HOLD=0 instances
module tb_dff_share_arb_160_163;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    int checks = 0;
    int failures = 0;
    int hc[2] = '{2, 0};
    int m_hold[2], m_ptr[2], m_q[2], m_gnt[2], m_valid[2], m_cnt[2], m_last[2];
    logic [W-1:0] rot_q[5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

    always #5 clk = ~clk;

    dff_share_arb_160_163_if #(.N(N), .W(W)) bus0 ();
    dff_share_arb_160_163_if #(.N(N), .W(W)) bus1 ();
    assign bus0.req  = req;
    assign bus0.d_in = din;
    assign bus1.req  = req;
    assign bus1.d_in = din;

    dff_share_arb_160_163 #(.N(N), .W(W), .HOLD_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    dff_share_arb_160_163 #(.N(N), .W(W), .HOLD_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_hold[m] = 0; m_ptr[m] = 0; m_q[m] = 0; m_gnt[m] = 0;
            m_valid[m] = 0; m_cnt[m] = 0; m_last[m] = 0;
        end
    endtask

    // one rising edge of the reference: hold countdown, else pick the next requester after the pointer
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int w;
            w = -1;
            m_gnt[m] = 0;
            if (m_hold[m] > 0) m_hold[m]--;
            else if (req != 0) begin
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_ptr[m] + k) % N]) w = (m_ptr[m] + k) % N;
                m_gnt[m] = 1 << w;
                m_q[m] = int'(din[w*W +: W]);
                m_valid[m] = 1;
                m_ptr[m] = (w + 1) % N;
                m_hold[m] = hc[m];
                m_cnt[m] = (m_cnt[m] + 1) % 65536;
                m_last[m] = w;
            end
        end
    endtask

    task automatic check_one(input int m, input logic [N-1:0] g, input logic [W-1:0] q,
                             input logic v, input logic b);
        chk($sformatf("gnt%0d", m), 32'(g), 32'(m_gnt[m]));
        chk($sformatf("q%0d", m), 32'(q), 32'(m_q[m]));
        chk($sformatf("valid%0d", m), 32'(v), 32'(m_valid[m]));
        chk($sformatf("busy%0d", m), 32'(b), 32'(m_hold[m] > 0));
    endtask

    task automatic check_all();
        check_one(0, bus0.gnt, bus0.q, bus0.valid, bus0.busy);
        check_one(1, bus1.gnt, bus1.q, bus1.valid, bus1.busy);
`ifdef DFF_SHARE_WRCNT_EN
        chk("wrcnt0", 32'(bus0.wrcnt), 32'(m_cnt[0]));
        chk("wrcnt1", 32'(bus1.wrcnt), 32'(m_cnt[1]));
        chk("last0", 32'(bus0.last_id), 32'(m_last[0]));
        chk("last1", 32'(bus1.last_id), 32'(m_last[1]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        din = '0;
        model_reset();
        #1;
        rst = 1'b1;
        req = 4'b1111;
        din = 32'h4332_2110;
        #1;
        check_all();
        repeat (10) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0100;
        din = 32'h00A5_0000;
        tick();
        chk("single_gnt", 32'(bus0.gnt), 32'h4);
        chk("single_q", 32'(bus0.q), 32'hA5);
        chk("single_busy", 32'(bus0.busy), 32'h1);
        req = '0;
        tick();
        chk("single_busy2", 32'(bus0.busy), 32'h1);
        tick();
        chk("single_idle", 32'(bus0.busy), 32'h0);
        tick();
        pulse_reset();
        req = 4'b1111;
        din = 32'h4332_2110;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("rot_gnt", 32'(bus0.gnt), 32'(1 << (g % 4)));
            chk("rot_q", 32'(bus0.q), 32'(rot_q[g]));
            tick();
            tick();
        end
        pulse_reset();
        req = 4'b0001;
        tick();
        chk("hold_g0", 32'(bus0.gnt), 32'h1);
        req = 4'b0010;
        tick();
        chk("hold_ign", 32'(bus0.gnt), 32'h0);
        tick();
        chk("hold_ign2", 32'(bus0.gnt), 32'h0);
        tick();
        chk("hold_g1", 32'(bus0.gnt), 32'h2);
        req = 4'b0001;
        tick();
        chk("mid_busy", 32'(bus0.busy), 32'h1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_busy", 32'(bus0.busy), 32'h0);
        chk("mid_rst_q", 32'(bus0.q), 32'h0);
        chk("mid_rst_valid", 32'(bus0.valid), 32'h0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1000;
        tick();
        chk("mid_rst_g3", 32'(bus0.gnt), 32'h8);
`ifdef DFF_SHARE_WRCNT_EN
        pulse_reset();
        req = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b2b_gnt", 32'(bus1.gnt), 32'(1 << (i % 2)));
        end
        chk("b2b_wrcnt", 32'(bus1.wrcnt), 32'd6);
        chk("b2b_last", 32'(bus1.last_id), 32'd1);
`endif
        for (int i = 0; i < 300; i++) begin
            req = N'($urandom);
            din = $urandom;
            if ($urandom_range(0, 60) == 0) pulse_reset();
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dff_share_arb_160_163.md
Name: dff_share_arb_160_163

Overview:
- Round-robin arbiter/controller that shares one W-bit bank of D flip-flops (a shared register) among N requesters.
- Each requester presents data and a request; the winner's data is loaded into the shared register with a one-cycle grant pulse.
- An optional hold window keeps the register stable after each write.
- Sits between requester logic and the shared register.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, width of the shared register and of each data slice
- HOLD_CYCLES, 2, idle cycles forced after each write before the next arbitration (0..15)

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous active-high reset
- REQ  input  N  per-requester write request, level
- D_IN  input  N*W  packed data; slice i = D_IN[i*W +: W]
- GNT  output  N  one-hot grant pulse, registered
- Q  output  W  shared register contents
- VALID  output  1  high once Q has been written since reset
- BUSY  output  1  high during the hold window

Behaviour:
- Reset, asynchronous, active-high. Forces:
  - state=IDLE, Q=0, GNT=0, VALID=0, BUSY=0
  - round-robin pointer PTR=0, hold counter=0
  - An in-progress hold window is abandoned.
- States: IDLE, HOLD.
- IDLE, REQ==0: no change, GNT=0.
- IDLE, REQ!=0, at the rising edge:
  - Winner = first set bit of REQ, searching from index PTR upward and wrapping at N.
  - GNT <= onehot(winner).
  - Q <= D_IN slice of the winner.
  - VALID <= 1.
  - PTR <= (winner+1) mod N.
  - If HOLD_CYCLES==0: stay in IDLE; back-to-back writes are possible every cycle.
  - Otherwise: state <= HOLD, counter <= HOLD_CYCLES, BUSY <= 1.
- HOLD:
  - GNT=0 and Q holds.
  - Counter decrements each edge.
  - The edge where the counter reaches 1 sets BUSY <= 0 and state <= IDLE.
  - BUSY is therefore high for exactly HOLD_CYCLES cycles.
  - REQ is ignored during HOLD.
- Latency: REQ sampled high at edge k -> GNT and Q updated immediately after edge k (one clock).
- GNT is a single-cycle pulse. A requester keeps REQ high until it sees its GNT bit, then must drop REQ within one cycle; otherwise it re-enters arbitration.
- A requester that drops REQ before being granted loses its turn with no side effect.
- Simultaneous requests are resolved strictly by PTR rotation. With all N requesting continuously, each is granted exactly once per N writes.
- Q changes only on a grant edge or on reset.
- Reset asserted mid-HOLD: the block is in IDLE on the first edge after release, and can grant on that edge if REQ!=0.

Optional Feature:
- Macro: DFF_SHARE_WRCNT_EN.
- Defined:
  - Adds output WRCNT (16 bits), reset 0.
  - WRCNT increments by 1 on every grant edge and wraps 0xFFFF -> 0.
  - Adds output LAST_ID (clog2(N) bits), reset 0, holding the index of the most recent winner.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package dff_share_pkg_160_163 contains:
  - state encoding localparams ST_IDLE=0, ST_HOLD=1
  - the clog2 constant function
  - the hold-counter width constant (4)
- Sub-module rr_pick_160_163: purely combinational.
  - Inputs: REQ, PTR.
  - Outputs: winner index and any-request flag.
  - Instantiated once.
- All registers live in the top module.

Test Plan:
- Reset: RST=1 for 100 ns with REQ=4'b1111 -> Q=0, GNT=0, VALID=0, BUSY=0 throughout.
- Single request (N=4, W=8, HOLD=2): REQ=4'b0100, slice 2=8'hA5 ->
  - Next edge: GNT=4'b0100, Q=8'hA5, VALID=1.
  - BUSY high for 2 cycles, then IDLE.
- Rotation: REQ=4'b1111 held, slices 8'h10/8'h21/8'h32/8'h43 -> grants in order 0,1,2,3,0, each 3 cycles apart; Q follows 10,21,32,43,10.
- Requests during hold are ignored: REQ=4'b0001 granted, then REQ=4'b0010 raised during BUSY -> GNT=0 while BUSY; grant 1 on the first edge after BUSY falls.
- Reset mid-hold: assert RST while BUSY=1 -> outputs return to reset values immediately; after release with REQ=4'b1000 -> GNT=4'b1000 on the next edge.
- HOLD_CYCLES=0 with DFF_SHARE_WRCNT_EN: REQ=4'b0011 for 6 cycles -> grants 0,1,0,1,0,1 on consecutive edges; WRCNT=6; LAST_ID=1.
